// File: rtl/lsb_message_embedder.sv
// lsb_message_embedder: hides a byte-stream message in the blue-channel LSB of an image, one bit per pixel in raster order
module lsb_message_embedder #(
  parameter int image_size = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2*image_size-3:0]   msg_len,
  input  logic [7:0]                msg_data,
  input  logic                      msg_valid,
  output logic                      msg_ready,
  output logic [image_size-1:0]     row,
  output logic [image_size-1:0]     col,
  output logic                      we,
  input  logic [23:0]               pix_in,
  output logic [23:0]               pix_out,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);
  localparam int lw = 2*image_size-2;
  localparam logic [lw-1:0] cap = lw'(1) << (2*image_size-3);
  typedef enum logic [1:0] {IDLE, LOAD, EMBED, DONE} state_t;
  state_t          state;
  logic [7:0]      shift;
  logic [2:0]      bit_cnt;
  logic [lw-1:0]   bytes_left;
  assign msg_ready = state == LOAD;
  assign we        = state == EMBED;
  assign busy      = state == LOAD || state == EMBED;
  assign done      = state == DONE;
  assign pix_out   = {pix_in[23:1], shift[7]};
  // {row,col} advances as one counter so the last pixel wraps cleanly to (0,0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      row        <= '0;
      col        <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          bytes_left <= msg_len > cap ? cap : msg_len;
          overflow   <= msg_len > cap;
          row        <= '0;
          col        <= '0;
          bit_cnt    <= '0;
          state      <= msg_len == '0 ? DONE : LOAD;
        end
        LOAD: if (msg_valid) begin
          shift   <= msg_data;
          bit_cnt <= '0;
          state   <= EMBED;
        end
        EMBED: begin
          shift      <= shift << 1;
          bit_cnt    <= bit_cnt + 3'd1;
          {row, col} <= {row, col} + 1'b1;
          if (bit_cnt == 3'd7) begin
            bytes_left <= bytes_left - 1'b1;
            state      <= bytes_left == lw'(1) ? DONE : LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
